// File: rtl/comparador_serial_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, verdict codes, default width.
package comparador_serial_pkg;

  localparam int N_PADRAO = 4;

  typedef enum logic [1:0] {
    OCIOSO          = 2'd0,
    IGUAL_ATE_AGORA = 2'd1,
    DECIDIDO        = 2'd2
  } estado_t;

  typedef enum logic [1:0] {
    VER_IGUAL = 2'd0,
    VER_MAIOR = 2'd1,
    VER_MENOR = 2'd2
  } veredito_t;

  function automatic logic um_quente(input logic a, input logic b, input logic c);
    return ({a, b, c} == 3'b100) || ({a, b, c} == 3'b010) || ({a, b, c} == 3'b001);
  endfunction

endpackage

// File: rtl/comparador_serial_if.sv
// Bit-stream input and word-result output bundle of the serial comparator.
interface comparador_serial_if;
  logic inicio;
  logic valido;
  logic in_maior;
  logic in_menor;
  logic in_igual;
  logic maior;
  logic menor;
  logic igual;
  logic pronto;
  logic ocupado;
  logic erro;

  modport master (
    output inicio, valido, in_maior, in_menor, in_igual,
    input  maior, menor, igual, pronto, ocupado, erro
  );

  modport slave (
    input  inicio, valido, in_maior, in_menor, in_igual,
    output maior, menor, igual, pronto, ocupado, erro
  );
endinterface

// File: rtl/comparador_serial_contador_bits.sv
// Valid-bit counter with clear/enable; ultimo flags that the next valid bit is bit 0 (the Nth).
module comparador_serial_contador_bits #(
  parameter int N = 4,
  localparam int CW = $clog2(N + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic limpa,
  input  logic habilita,
  output logic ultimo
);

  logic [CW-1:0] cnt;

  // A clear together with an enable means the clearing bit itself is counted.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (limpa)
      cnt <= habilita ? CW'(1) : '0;
    else if (habilita)
      cnt <= cnt + CW'(1);
  end

  assign ultimo = (cnt == CW'(N - 1));

endmodule

// File: rtl/comparador_serial.sv
// MSB-first serial N-bit magnitude comparator fed by an upstream 1-bit comparator stage.
//  state           | meaning
//  OCIOSO          | no word in progress
//  IGUAL_ATE_AGORA | all bits so far equal
//  DECIDIDO        | differing bit seen, verdict fixed, bits only counted
module comparador_serial
  import comparador_serial_pkg::*;
#(
  parameter int N = N_PADRAO
) (
  input logic                clk,
  input logic                rst_n,
  comparador_serial_if.slave bus
);

  estado_t   estado, estado_n, est_base;
  veredito_t veredito, veredito_n, ver_base;
  logic      err, err_n, err_base;
  logic      bit_ok, fim, ultimo;
  logic      maior_q, menor_q, igual_q, erro_q, pronto_q, ocupado_q;
  logic      maior_n, menor_n, igual_n, erro_n, pronto_n, ocupado_n;

  comparador_serial_contador_bits #(.N(N)) u_contador (
    .clk      (clk),
    .rst_n    (rst_n),
    .limpa    (bus.inicio || fim),
    .habilita (bit_ok && !fim),
    .ultimo   (ultimo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado    <= OCIOSO;
      veredito  <= VER_IGUAL;
      err       <= 1'b0;
      maior_q   <= 1'b0;
      menor_q   <= 1'b0;
      igual_q   <= 1'b0;
      erro_q    <= 1'b0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado    <= estado_n;
      veredito  <= veredito_n;
      err       <= err_n;
      maior_q   <= maior_n;
      menor_q   <= menor_n;
      igual_q   <= igual_n;
      erro_q    <= erro_n;
      pronto_q  <= pronto_n;
      ocupado_q <= ocupado_n;
    end
  end

  // inicio wipes the word first, so a bit arriving with it is the MSB of the fresh word.
  always_comb begin
    est_base   = bus.inicio ? IGUAL_ATE_AGORA : estado;
    ver_base   = bus.inicio ? VER_IGUAL : veredito;
    err_base   = bus.inicio ? 1'b0 : err;
    bit_ok     = bus.valido && (est_base != OCIOSO);
    fim        = bit_ok && (bus.inicio ? (N == 1) : ultimo);
    estado_n   = est_base;
    veredito_n = ver_base;
    err_n      = err_base;
    if (bit_ok) begin
      if (!um_quente(bus.in_maior, bus.in_menor, bus.in_igual)) begin
        err_n = 1'b1;
      end else if (est_base == IGUAL_ATE_AGORA) begin
        if (bus.in_maior) begin
          estado_n   = DECIDIDO;
          veredito_n = VER_MAIOR;
        end else if (bus.in_menor) begin
          estado_n   = DECIDIDO;
          veredito_n = VER_MENOR;
        end
      end
    end
    if (fim)
      estado_n = OCIOSO;
  end

  always_comb begin
    pronto_n  = fim;
    ocupado_n = (estado_n != OCIOSO);
    maior_n   = maior_q;
    menor_n   = menor_q;
    igual_n   = igual_q;
    erro_n    = erro_q;
    if (fim) begin
      maior_n = !err_n && (veredito_n == VER_MAIOR);
      menor_n = !err_n && (veredito_n == VER_MENOR);
      igual_n = !err_n && (veredito_n == VER_IGUAL);
      erro_n  = err_n;
    end
  end

  assign bus.maior   = maior_q;
  assign bus.menor   = menor_q;
  assign bus.igual   = igual_q;
  assign bus.erro    = erro_q;
  assign bus.pronto  = pronto_q;
  assign bus.ocupado = ocupado_q;

endmodule

// File: tb/tb_comparador_serial.sv
// Scoreboard bench: word-level expectations from integer comparison, checked on every pronto.
module tb_comparador_serial;
  localparam int N = 4;

  typedef struct packed {
    logic maior;
    logic menor;
    logic igual;
    logic erro;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_visto;
  always #5 clk = ~clk;

  comparador_serial_if bus();

  comparador_serial #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  res_t esperado[$];
  int total = 0;
  int falhas = 0;

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] req);
    total++;
    if (atual !== req) begin
      falhas++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, atual, req, $time);
    end
  endtask

  function automatic res_t modelo(input int a, input int b, input bit corrompido);
    res_t r;
    if (corrompido) begin
      r = '0;
      r.erro = 1'b1;
    end else begin
      r.maior = (a > b);
      r.menor = (a < b);
      r.igual = (a == b);
      r.erro  = 1'b0;
    end
    return r;
  endfunction

  // reset takes effect at the edge that samples it low
  always @(posedge clk) rst_visto <= rst_n;

  res_t ant = '0;
  always @(negedge clk) begin
    res_t cur;
    res_t e;
    cur = {bus.maior, bus.menor, bus.igual, bus.erro};
    if (!rst_visto) begin
      chk("reset_saidas", cur, 0);
      chk("reset_pronto", bus.pronto, 0);
      chk("reset_ocupado", bus.ocupado, 0);
      ant = '0;
    end else if (bus.pronto) begin
      if (esperado.size() == 0) begin
        chk("pronto_inesperado", bus.pronto, 0);
      end else begin
        e = esperado.pop_front();
        chk("resultado", cur, e);
      end
      ant = cur;
    end else begin
      chk("saidas_estaveis", cur, ant);
    end
  end

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic lixo();
    bus.in_maior = 1'($urandom);
    bus.in_menor = 1'($urandom);
    bus.in_igual = 1'($urandom);
  endtask

  task automatic bit_(input logic ini, input logic m, input logic me, input logic ig);
    bus.inicio   = ini;
    bus.valido   = 1'b1;
    bus.in_maior = m;
    bus.in_menor = me;
    bus.in_igual = ig;
    ciclo();
    bus.inicio = 1'b0;
    bus.valido = 1'b0;
    lixo();
  endtask

  task automatic bits_de(input int a, input int b, input int i, output logic m, output logic me, output logic ig);
    m  = a[i] & ~b[i];
    me = ~a[i] & b[i];
    ig = (a[i] == b[i]);
  endtask

  task automatic padrao_ruim(output logic m, output logic me, output logic ig);
    logic [2:0] p;
    case ($urandom_range(0, 4))
      0: p = 3'b000;
      1: p = 3'b110;
      2: p = 3'b011;
      3: p = 3'b101;
      default: p = 3'b111;
    endcase
    {m, me, ig} = p;
  endtask

  task automatic palavra(input int a, input int b, input int pos_err, input bit err_fixo,
                         input int gap_max, input int gap_bit, input int gap_n);
    logic m, me, ig;
    int n;
    for (int i = N - 1; i >= 0; i--) begin
      bits_de(a, b, i, m, me, ig);
      if (i == pos_err) begin
        if (err_fixo) {m, me, ig} = 3'b110;
        else padrao_ruim(m, me, ig);
      end
      if (i == 0) esperado.push_back(modelo(a, b, pos_err >= 0));
      bit_(i == N - 1, m, me, ig);
      if (i > 0) begin
        chk("ocupado_palavra", bus.ocupado, 1);
        chk("sem_pronto_meio", bus.pronto, 0);
        n = (i == gap_bit) ? gap_n : int'($urandom_range(0, gap_max));
        repeat (n) begin
          ciclo();
          lixo();
          chk("ocupado_lacuna", bus.ocupado, 1);
        end
      end else begin
        chk("ocupado_fim", bus.ocupado, 0);
        chk("pronto_apos_ultimo", bus.pronto, 1);
      end
    end
  endtask

  task automatic parcial(input int a, input int b, input int nbits);
    logic m, me, ig;
    for (int k = 0; k < nbits; k++) begin
      bits_de(a, b, N - 1 - k, m, me, ig);
      bit_(k == 0, m, me, ig);
    end
  endtask

  initial begin
    int t;
    logic m, me, ig;
    bus.inicio = 1'b0;
    bus.valido = 1'b0;
    bus.in_maior = 1'b0;
    bus.in_menor = 1'b0;
    bus.in_igual = 1'b0;
    rst_n = 1'b0;
    repeat (2) ciclo();
    rst_n = 1'b1;
    ciclo();

    palavra(4'b1010, 4'b1010, -1, 0, 0, -1, 0);
    repeat (2) ciclo();
    palavra(4'b1000, 4'b0111, -1, 0, 0, -1, 0);
    palavra(4'b0111, 4'b1000, -1, 0, 0, -1, 0);
    ciclo();
    palavra(4'b0011, 4'b0010, -1, 0, 0, 2, 2);
    parcial(4'b0101, 4'b0011, 2);
    palavra(4'b0001, 4'b0001, -1, 0, 0, -1, 0);
    palavra(4'b1100, 4'b0100, 2, 1, 0, -1, 0);
    palavra(4'b0101, 4'b0101, -1, 0, 1, -1, 0);

    // reset lands on bit 2 of a word in progress
    parcial(4'b1111, 4'b0000, 1);
    rst_n = 1'b0;
    bits_de(15, 0, 2, m, me, ig);
    bit_(1'b0, m, me, ig);
    ciclo();
    rst_n = 1'b1;
    chk("ocupado_apos_reset", bus.ocupado, 0);
    repeat (5) begin
      bit_(1'b0, 1'b1, 1'b0, 1'b0);
      chk("valido_sem_inicio", bus.pronto, 0);
      chk("ocioso_apos_reset", bus.ocupado, 0);
    end
    palavra(4'b0110, 4'b0010, -1, 0, 0, -1, 0);

    repeat (150) begin
      int a, b, pe;
      a = int'($urandom_range(0, 15));
      b = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 15));
      pe = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      if ($urandom_range(0, 9) == 0) parcial(int'($urandom_range(0, 15)), a, int'($urandom_range(1, N - 1)));
      palavra(a, b, pe, 0, 2, -1, 0);
      if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 3))) ciclo();
    end

    t = 0;
    while (esperado.size() != 0 && t < 20) begin
      ciclo();
      t++;
    end
    repeat (3) ciclo();
    chk("fila_vazia", esperado.size(), 0);
    $display("%0d/%0d checks passed", total - falhas, total);
    $finish;
  end

endmodule
